// File: rtl/nand_phy_cmd_seq.sv
// NAND PHY command sequencer: runs one CMD/ADDR/write/read bus cycle as
// SETUP/PULSE/HOLD phases and drives registered PHY control pins.
module nand_phy_cmd_seq #(
   parameter int unsigned DQ_WIDTH = 8,
   parameter int unsigned NUM_CE   = 8,
   parameter int unsigned TCNT_W   = 4
) (
   input  logic                v_clk0,
   input  logic                v_rstn0,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_type,
   input  logic [3:0]          cmd_ce,
   input  logic [DQ_WIDTH-1:0] cmd_data,
   input  logic                cmd_keep_ce,
   input  logic                cfg_sync,
   input  logic                cfg_wp_n,
   input  logic [TCNT_W-1:0]   t_setup,
   input  logic [TCNT_W-1:0]   t_pulse,
   input  logic [TCNT_W-1:0]   t_hold,
   input  logic [DQ_WIDTH-1:0] v_rd_data_comb,
   output logic                v_ctrl_cle,
   output logic                v_ctrl_ale,
   output logic                v_ctrl_wrn,
   output logic                v_ctrl_wpn,
   output logic                v_ctrl_wen,
   output logic                v_ctrl_wen_sel,
   output logic [NUM_CE-1:0]   v_ctrl_cen,
   output logic                v_dq_oe_n,
   output logic                v_dqs_oe_n,
   output logic [DQ_WIDTH-1:0] v_wr_data_rise,
   output logic [DQ_WIDTH-1:0] v_wr_data_fall,
   output logic                rsp_valid,
   output logic [DQ_WIDTH-1:0] rsp_data,
   output logic                err_ce
);

   typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_t;

   state_t              r_state;
   logic [TCNT_W-1:0]   r_cnt;
   logic [TCNT_W-1:0]   r_t_pulse;
   logic [TCNT_W-1:0]   r_t_hold;
   logic [1:0]          r_type;
   logic [3:0]          r_ce;
   logic [DQ_WIDTH-1:0] r_data;
   logic                r_keep_req;
   logic                r_keep_act;
   logic                r_sync;

   state_t              w_state_d;
   logic [TCNT_W-1:0]   w_cnt_d;
   logic                w_accept;
   logic                w_ce_bad;
   logic                w_start;
   logic                w_cnt_zero;
   logic [1:0]          w_type_d;
   logic [3:0]          w_ce_d;
   logic [DQ_WIDTH-1:0] w_data_d;
   logic                w_sync_d;
   logic                w_keep_act_d;
   logic                w_active;
   logic                w_pulse;
   logic                w_rd;
   logic                w_rd_cap;
   logic [NUM_CE-1:0]   w_ce_mask;

   always_comb begin
      w_accept     = cmd_valid & cmd_ready;
      w_ce_bad     = ({28'd0, cmd_ce} >= NUM_CE);
      w_start      = w_accept & ~w_ce_bad;
      w_cnt_zero   = (r_cnt == '0);
      w_type_d     = w_start ? cmd_type : r_type;
      w_ce_d       = w_start ? cmd_ce : r_ce;
      w_data_d     = w_start ? cmd_data : r_data;
      w_sync_d     = w_start ? cfg_sync : r_sync;
      w_rd_cap     = (r_state == StPulse) & w_cnt_zero & (r_type == 2'b11);

      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      case (r_state)
         StIdle: begin
            if (w_start) begin
               w_state_d = StSetup;
               w_cnt_d   = t_setup;
            end
         end
         StSetup: begin
            if (w_cnt_zero) begin
               w_state_d = StPulse;
               w_cnt_d   = r_t_pulse;
            end else begin
               w_cnt_d = r_cnt - TCNT_W'(1);
            end
         end
         StPulse: begin
            if (w_cnt_zero) begin
               w_state_d = StHold;
               w_cnt_d   = r_t_hold;
            end else begin
               w_cnt_d = r_cnt - TCNT_W'(1);
            end
         end
         StHold: begin
            if (w_cnt_zero) begin
               w_state_d = StIdle;
            end else begin
               w_cnt_d = r_cnt - TCNT_W'(1);
            end
         end
         default: w_state_d = StIdle;
      endcase

      // A kept CE is dropped as soon as a new command takes over the bus.
      if (w_start) begin
         w_keep_act_d = 1'b0;
      end else if ((r_state == StHold) && w_cnt_zero) begin
         w_keep_act_d = r_keep_req;
      end else begin
         w_keep_act_d = r_keep_act;
      end

      w_active  = (w_state_d != StIdle);
      w_pulse   = (w_state_d == StPulse);
      w_rd      = (w_type_d == 2'b11);
      w_ce_mask = NUM_CE'(1) << w_ce_d;
   end

   // Outputs are registered from next-state values so pins align with the state they belong to.
   always_ff @(posedge v_clk0 or negedge v_rstn0) begin
      if (!v_rstn0) begin
         r_state        <= StIdle;
         r_cnt          <= '0;
         r_t_pulse      <= '0;
         r_t_hold       <= '0;
         r_type         <= 2'b00;
         r_ce           <= 4'd0;
         r_data         <= '0;
         r_keep_req     <= 1'b0;
         r_keep_act     <= 1'b0;
         r_sync         <= 1'b0;
         cmd_ready      <= 1'b0;
         v_ctrl_cle     <= 1'b0;
         v_ctrl_ale     <= 1'b0;
         v_ctrl_wrn     <= 1'b1;
         v_ctrl_wen     <= 1'b1;
         v_ctrl_wen_sel <= 1'b1;
         v_ctrl_wpn     <= 1'b0;
         v_ctrl_cen     <= '1;
         v_dq_oe_n      <= 1'b1;
         v_dqs_oe_n     <= 1'b1;
         v_wr_data_rise <= '0;
         v_wr_data_fall <= '0;
         rsp_valid      <= 1'b0;
         rsp_data       <= '0;
         err_ce         <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_type     <= w_type_d;
         r_ce       <= w_ce_d;
         r_data     <= w_data_d;
         r_sync     <= w_sync_d;
         r_keep_act <= w_keep_act_d;
         if (w_start) begin
            r_t_pulse  <= t_pulse;
            r_t_hold   <= t_hold;
            r_keep_req <= cmd_keep_ce;
         end

         cmd_ready  <= (w_state_d == StIdle);
         err_ce     <= w_accept & w_ce_bad;
         v_ctrl_wpn <= cfg_wp_n;
         rsp_valid  <= w_rd_cap;
         if (w_rd_cap) begin
            rsp_data <= v_rd_data_comb;
         end

         v_ctrl_cen <= (w_active | w_keep_act_d) ? ~w_ce_mask : '1;
         v_dq_oe_n  <= ~(w_active & ~w_rd);
         v_ctrl_wrn <= ~(w_pulse & w_rd);
         if (w_active & ~w_rd) begin
            v_wr_data_rise <= w_data_d;
            v_wr_data_fall <= w_data_d;
         end

         if (w_sync_d) begin
            v_ctrl_cle     <= w_pulse & ((w_type_d == 2'b00) | w_type_d[1]);
            v_ctrl_ale     <= w_pulse & ((w_type_d == 2'b01) | w_type_d[1]);
            v_ctrl_wen     <= 1'b1;
            v_ctrl_wen_sel <= ~w_active;
            v_dqs_oe_n     <= ~(w_pulse & (w_type_d == 2'b10));
         end else begin
            v_ctrl_cle     <= w_active & (w_type_d == 2'b00);
            v_ctrl_ale     <= w_active & (w_type_d == 2'b01);
            v_ctrl_wen     <= ~(w_pulse & ~w_rd);
            v_ctrl_wen_sel <= 1'b1;
            v_dqs_oe_n     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nand_phy_cmd_seq.sv
// Scoreboard bench for nand_phy_cmd_seq: stimulus pushes per-command expectations,
// a monitor summarises each busy window of the DUT and compares it.
module tb_nand_phy_cmd_seq;

   localparam int DQW = 8;
   localparam int NCE = 8;
   localparam int TW  = 4;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [1:0]      cmd_type = 2'b00;
   logic [3:0]      cmd_ce = 4'd0;
   logic [DQW-1:0]  cmd_data = '0;
   logic            cmd_keep_ce = 1'b0;
   logic            cfg_sync = 1'b0;
   logic            cfg_wp_n = 1'b1;
   logic [TW-1:0]   t_setup = '0;
   logic [TW-1:0]   t_pulse = '0;
   logic [TW-1:0]   t_hold = '0;
   logic [DQW-1:0]  rd_comb;
   logic            cle, ale, wrn, wpn, wen, wen_sel;
   logic [NCE-1:0]  cen;
   logic            dq_oe_n, dqs_oe_n;
   logic [DQW-1:0]  wr_rise, wr_fall;
   logic            rsp_valid;
   logic [DQW-1:0]  rsp_data;
   logic            err_ce;

   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Read data changes every cycle so only the correct capture cycle yields the expected byte.
   function automatic logic [7:0] rd_at(input int unsigned c);
      return 8'((c * 37 + 11) ^ (c >> 3));
   endfunction
   assign rd_comb = rd_at(cyc);

   nand_phy_cmd_seq #(.DQ_WIDTH(DQW), .NUM_CE(NCE), .TCNT_W(TW)) dut (
      .v_clk0(clk), .v_rstn0(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_ce(cmd_ce),
      .cmd_data(cmd_data), .cmd_keep_ce(cmd_keep_ce), .cfg_sync(cfg_sync), .cfg_wp_n(cfg_wp_n),
      .t_setup(t_setup), .t_pulse(t_pulse), .t_hold(t_hold), .v_rd_data_comb(rd_comb),
      .v_ctrl_cle(cle), .v_ctrl_ale(ale), .v_ctrl_wrn(wrn), .v_ctrl_wpn(wpn),
      .v_ctrl_wen(wen), .v_ctrl_wen_sel(wen_sel), .v_ctrl_cen(cen),
      .v_dq_oe_n(dq_oe_n), .v_dqs_oe_n(dqs_oe_n),
      .v_wr_data_rise(wr_rise), .v_wr_data_fall(wr_fall),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_ce(err_ce)
   );

   typedef struct {
      bit       is_err;
      int       len;
      int       n_cle, n_ale, n_wen, n_wrn, n_dqoe, n_dqsoe, n_wsel;
      int       first_act, last_act;
      bit       has_rsp;
      int       rsp_idx;
      logic [7:0] rsp_byte;
      bit       chk_wdata;
      logic [7:0] wdata;
      logic [7:0] cen_busy;
      logic [7:0] cen_idle;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what one accepted command should look like on the pins.
   function automatic exp_t model(input logic [1:0] ty, input logic [3:0] ce, input logic [7:0] d,
                                  input bit keep, input bit sync, input int ts, input int tp,
                                  input int th, input int unsigned acc_cyc);
      exp_t e;
      int   p;
      p = tp + 1;
      e = '{default: 0};
      if (int'(ce) >= NCE) begin
         e.is_err = 1'b1;
         return e;
      end
      e.len       = ts + tp + th + 3;
      e.first_act = ts + 1;
      e.last_act  = ts + tp + 1;
      e.cen_busy  = ~(8'h01 << ce);
      e.cen_idle  = keep ? e.cen_busy : 8'hFF;
      e.chk_wdata = (ty != 2'b11);
      e.wdata     = d;
      e.n_dqoe    = (ty != 2'b11) ? e.len : 0;
      e.n_wrn     = (ty == 2'b11) ? p : 0;
      e.has_rsp   = (ty == 2'b11);
      e.rsp_idx   = ts + tp + 2;
      e.rsp_byte  = rd_at(acc_cyc + 32'(ts + tp + 2));
      if (!sync) begin
         e.n_cle = (ty == 2'b00) ? e.len : 0;
         e.n_ale = (ty == 2'b01) ? e.len : 0;
         e.n_wen = (ty != 2'b11) ? p : 0;
      end else begin
         e.n_wsel  = e.len;
         e.n_cle   = (ty == 2'b00 || ty[1]) ? p : 0;
         e.n_ale   = (ty == 2'b01 || ty[1]) ? p : 0;
         e.n_dqsoe = (ty == 2'b10) ? p : 0;
      end
      return e;
   endfunction

   task automatic issue(input logic [1:0] ty, input logic [3:0] ce, input logic [7:0] d,
                        input bit keep, input bit sync, input int ts, input int tp, input int th);
      int guard = 0;
      while (cmd_ready !== 1'b1 && guard < 500) begin
         // Noise while busy: must all be ignored.
         cmd_valid   = 1'($urandom);
         cmd_type    = 2'($urandom);
         cmd_ce      = 4'($urandom);
         cmd_data    = 8'($urandom);
         cmd_keep_ce = 1'($urandom);
         cfg_sync    = 1'($urandom);
         t_setup     = 4'($urandom);
         t_pulse     = 4'($urandom);
         t_hold      = 4'($urandom);
         cfg_wp_n    = 1'($urandom);
         @(negedge clk);
         guard++;
      end
      chk("ready_wait", cmd_ready, 1);
      cmd_valid   = 1'b1;
      cmd_type    = ty;
      cmd_ce      = ce;
      cmd_data    = d;
      cmd_keep_ce = keep;
      cfg_sync    = sync;
      t_setup     = 4'(ts);
      t_pulse     = 4'(tp);
      t_hold      = 4'(th);
      cfg_wp_n    = 1'($urandom);
      q.push_back(model(ty, ce, d, keep, sync, ts, tp, th, cyc));
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_ctrl"}, {cmd_ready, cle, ale, wrn, wen, wen_sel, wpn, dq_oe_n, dqs_oe_n,
                          rsp_valid, err_ce}, 11'b000_111_0_11_00);
      chk({tag, "_cen"}, cen, 8'hFF);
      chk({tag, "_data"}, {wr_rise, wr_fall, rsp_data}, 24'h0);
   endtask

   // Monitor
   bit         m_in = 1'b0;
   int         m_idx, m_cle, m_ale, m_wen, m_wrn, m_dqoe, m_dqsoe, m_wsel;
   int         m_first, m_last, m_rsp_cnt, m_rsp_at, m_cen_cnt;
   logic [7:0] m_rsp_d, m_wr, m_wf, m_cen0;
   logic [7:0] m_idle_cen = 8'hFF;

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rstn) begin
            m_in = 1'b0;
            m_idle_cen = 8'hFF;
         end else begin
            chk("wpn_follow", wpn, cfg_wp_n);
            if (!cmd_ready) begin
               if (!m_in) begin
                  m_in = 1'b1; m_idx = 0; m_cle = 0; m_ale = 0; m_wen = 0; m_wrn = 0;
                  m_dqoe = 0; m_dqsoe = 0; m_wsel = 0; m_first = -1; m_last = -1;
                  m_rsp_cnt = 0; m_rsp_at = -1; m_rsp_d = '0; m_cen_cnt = 0;
                  m_wr = wr_rise; m_wf = wr_fall; m_cen0 = cen;
               end
               chk("err_in_busy", err_ce, 0);
               if (cle) m_cle++;
               if (ale) m_ale++;
               if (!wen) m_wen++;
               if (!wrn) m_wrn++;
               if (!dq_oe_n) m_dqoe++;
               if (!dqs_oe_n) m_dqsoe++;
               if (!wen_sel) m_wsel++;
               if (cen == m_cen0) m_cen_cnt++;
               if (!wen || !wrn || (!wen_sel && (cle || ale))) begin
                  if (m_first < 0) m_first = m_idx;
                  m_last = m_idx;
               end
               if (rsp_valid) begin
                  m_rsp_cnt++; m_rsp_at = m_idx; m_rsp_d = rsp_data;
               end
               m_idx++;
            end else begin
               if (m_in) begin
                  m_in = 1'b0;
                  chk("cycle_expected", q.size() > 0, 1);
                  if (q.size() > 0) begin
                     e = q.pop_front();
                     chk("cycle_not_err", e.is_err, 0);
                     chk("busy_len", m_idx, e.len);
                     chk("cen_busy", m_cen0, e.cen_busy);
                     chk("cen_steady", m_cen_cnt, e.len);
                     chk("cle_cycles", m_cle, e.n_cle);
                     chk("ale_cycles", m_ale, e.n_ale);
                     chk("wen_low_cycles", m_wen, e.n_wen);
                     chk("wrn_low_cycles", m_wrn, e.n_wrn);
                     chk("dq_oe_cycles", m_dqoe, e.n_dqoe);
                     chk("dqs_oe_cycles", m_dqsoe, e.n_dqsoe);
                     chk("wen_sel_low_cycles", m_wsel, e.n_wsel);
                     chk("strobe_first", m_first, e.first_act);
                     chk("strobe_last", m_last, e.last_act);
                     chk("rsp_count", m_rsp_cnt, e.has_rsp);
                     if (e.has_rsp) begin
                        chk("rsp_index", m_rsp_at, e.rsp_idx);
                        chk("rsp_data", m_rsp_d, e.rsp_byte);
                     end
                     if (e.chk_wdata) begin
                        chk("wdata_rise", m_wr, e.wdata);
                        chk("wdata_fall", m_wf, e.wdata);
                     end
                     m_idle_cen = e.cen_idle;
                  end
               end
               if (err_ce) begin
                  chk("err_expected", q.size() > 0, 1);
                  if (q.size() > 0) begin
                     e = q.pop_front();
                     chk("err_is_bad_ce", e.is_err, 1);
                  end
               end
               chk("idle_pins", {cle, ale, wen, wrn, wen_sel, dq_oe_n, dqs_oe_n, rsp_valid},
                   8'b0011_1110);
               chk("idle_cen", cen, m_idle_cen);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, actual running required done");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      #12;
      check_reset_outs("por");
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1 chk("ready_before_clk", cmd_ready, 0);
      @(posedge clk);
      #1 chk("ready_after_release", cmd_ready, 1);
      @(negedge clk);

      issue(2'b00, 4'd2, 8'h70, 1'b0, 1'b0, 1, 2, 1);
      issue(2'b11, 4'd0, 8'h00, 1'b0, 1'b0, 0, 3, 0);
      issue(2'b00, 4'd9, 8'h11, 1'b0, 1'b0, 0, 0, 0);
      repeat (2) @(negedge clk);
      issue(2'b01, 4'd5, 8'h12, 1'b1, 1'b0, 0, 1, 0);
      repeat (3) @(negedge clk);
      issue(2'b10, 4'd5, 8'h34, 1'b1, 1'b0, 1, 0, 1);
      repeat (3) @(negedge clk);
      issue(2'b00, 4'd5, 8'hFF, 1'b0, 1'b0, 0, 0, 0);
      issue(2'b10, 4'd1, 8'h5A, 1'b0, 1'b1, 0, 1, 0);
      issue(2'b11, 4'd7, 8'h00, 1'b0, 1'b1, 1, 0, 2);

      for (int i = 0; i < 80; i++) begin
         logic [3:0] ce;
         ce = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         issue(2'($urandom), ce, 8'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset in the middle of a read's PULSE phase.
      issue(2'b11, 4'd1, 8'h00, 1'b0, 1'b0, 0, 3, 0);
      repeat (2) @(negedge clk);
      #1 rstn = 1'b0;
      q.delete();
      #1 check_reset_outs("mid_pulse");
      repeat (2) @(negedge clk);
      check_reset_outs("held");
      rstn = 1'b1;
      #1 chk("ready_before_clk2", cmd_ready, 0);
      @(posedge clk);
      #1 chk("ready_after_release2", cmd_ready, 1);
      @(negedge clk);
      issue(2'b01, 4'd3, 8'hC3, 1'b0, 1'b0, 0, 0, 0);

      guard = 0;
      while (q.size() != 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nand_phy_cmd_seq.md
NAND_PHY_CMD_SEQ -- requirements
Module: nand_phy_cmd_seq

Interface
REQ-001 SHALL have parameter DQ_WIDTH, default 8, meaning the data-bus width per bus cycle.
REQ-002 SHALL have parameter NUM_CE, default 8, meaning the number of chip enables driven (range 1..16).
REQ-003 SHALL have parameter TCNT_W, default 4, meaning the width of each timing-count input.
REQ-004 SHALL have ports, clock and reset first:
- v_clk0  in  1  sole clock.
- v_rstn0  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_type  in  2  cycle type: 00 CMD latch, 01 ADDR latch, 10 data write, 11 data read.
- cmd_ce  in  4  target chip-enable index.
- cmd_data  in  DQ_WIDTH  command, address or write byte.
- cmd_keep_ce  in  1  hold CE# low after the cycle.
- cfg_sync  in  1  0 = async mode (WE# toggled), 1 = sync mode (free-running NAND clock).
- cfg_wp_n  in  1  write-protect request.
- t_setup, t_pulse, t_hold  in  TCNT_W each  phase lengths minus one.
- v_rd_data_comb  in  DQ_WIDTH  async read data from the PHY.
- v_ctrl_cle, v_ctrl_ale, v_ctrl_wrn, v_ctrl_wpn, v_ctrl_wen, v_ctrl_wen_sel  out  1 each  PHY control.
- v_ctrl_cen  out  NUM_CE  chip enables, active-low.
- v_dq_oe_n, v_dqs_oe_n  out  1 each  output-enable strobes, active-low.
- v_wr_data_rise, v_wr_data_fall  out  DQ_WIDTH each  write data.
- rsp_valid  out  1  one-cycle read-data strobe.
- rsp_data  out  DQ_WIDTH  captured read byte.
- err_ce  out  1  one-cycle pulse for a rejected CE index.

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD; all outputs registered.
REQ-006 SHALL assert cmd_ready only in IDLE; acceptance = cmd_valid & cmd_ready; cmd_type, cmd_ce, cmd_data, cmd_keep_ce and cfg_sync SHALL be latched at acceptance and held for the whole cycle.
REQ-007 SHALL, on acceptance with cmd_ce >= NUM_CE, stay in IDLE, drive no pins and pulse err_ce for exactly one cycle.
REQ-008 SHALL spend exactly t_setup+1, t_pulse+1 and t_hold+1 cycles in SETUP, PULSE and HOLD; a count of 0 gives one cycle.
REQ-009 SHALL return HOLD->IDLE; cmd_ready SHALL be high on the first IDLE cycle; the minimum command period is t_setup+t_pulse+t_hold+4 cycles.
REQ-010 SHALL drive v_ctrl_cen[cmd_ce] low from SETUP through HOLD; all other bits SHALL stay high.
REQ-011 SHALL, in IDLE, keep the last CE low if the previous command had cmd_keep_ce=1; otherwise all CE# bits SHALL be high. A new accepted command SHALL replace that CE.
REQ-012 SHALL, in async CMD/ADDR/write cycles, do all of the following:
- Drive v_ctrl_wen_sel=1.
- Assert CLE (type 00) or ALE (type 01) from SETUP through HOLD.
- Drive v_dq_oe_n=0 and v_wr_data_rise=v_wr_data_fall=cmd_data from SETUP through HOLD.
- Drive v_ctrl_wen=0 only in PULSE.
REQ-013 SHALL, in an async read, drive v_ctrl_wrn=0 only in PULSE and keep v_dq_oe_n=1. It SHALL register v_rd_data_comb into rsp_data on the last PULSE cycle and pulse rsp_valid on the first HOLD cycle.
REQ-014 SHALL, in sync mode, do all of the following:
- Drive v_ctrl_wen_sel=0 from SETUP through HOLD.
- Assert CLE/ALE for latch cycles, or both CLE and ALE for data cycles, only in PULSE.
- Drive v_dqs_oe_n=0 for writes in PULSE only.
- Drive v_ctrl_wrn=0 for reads in PULSE, with capture timing per REQ-013.
REQ-015 SHALL drive v_ctrl_wpn as cfg_wp_n registered once; it SHALL update in any state.
REQ-016 SHALL ignore cmd_valid outside IDLE, and SHALL ignore changes to t_* and cfg_sync during a cycle.

Reset
REQ-017 SHALL, while v_rstn0=0, force the following values asynchronously:
- State IDLE; cmd_ready=0; v_ctrl_cle=v_ctrl_ale=0.
- v_ctrl_wrn=1, v_ctrl_wen=1, v_ctrl_wen_sel=1, v_ctrl_wpn=0.
- v_ctrl_cen all ones; v_dq_oe_n=v_dqs_oe_n=1.
- Write data, rsp_data and keep-CE state all 0; rsp_valid=err_ce=0.
REQ-018 SHALL abort any in-flight cycle on reset with no rsp_valid, and SHALL raise cmd_ready on the first clock after release.

Verification
REQ-019 Async CMD: type 00, ce 2, data 0x70, t=1/2/1, cfg_sync=0 -> v_ctrl_cen=0xFB for 7 cycles, CLE high 7 cycles, WE# low exactly 3 cycles, v_wr_data=0x70, cmd_ready after 8 cycles.
REQ-020 Async read: type 11, ce 0, t=0/3/0, v_rd_data_comb=0xA5 -> RE# low 4 cycles, rsp_valid one cycle with rsp_data=0xA5, v_dq_oe_n stays 1.
REQ-021 Bad CE: cmd_ce=9 with NUM_CE=8 -> err_ce one-cycle pulse, v_ctrl_cen stays 0xFF, cmd_ready stays 1.
REQ-022 Keep-CE chain: ADDR with keep_ce=1 on ce 5, then a write -> v_ctrl_cen=0xDF continuously across IDLE; after a final keep_ce=0 -> 0xFF.
REQ-023 Sync write: cfg_sync=1, type 10, t=0/1/0 -> wen_sel=0 for 4 cycles, CLE=ALE=1 and v_dqs_oe_n=0 for 2 PULSE cycles.
REQ-024 Reset mid-PULSE during a read -> outputs at REQ-017 values immediately, no rsp_valid, cmd_ready=1 one clock after release.
